// File: rtl/inst_fetch_queue_pkg.sv
// Core-wide fetch/decode constants and the fetch entry payload shared with the decode stage.
package inst_fetch_queue_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    // One fetched instruction as carried from fetch into decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            misalign;
    } fetch_entry_t;

    // A PC not on a 4-byte boundary tags the entry so decode can raise the fault.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling queue: in-order circular buffer with valid/ready on both
// sides, single-cycle flush for redirects, and a misalign tag carried with each entry.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = inst_fetch_queue_pkg::XLEN,
    parameter int unsigned ILEN  = inst_fetch_queue_pkg::ILEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_inst,
    output logic                     out_misalign,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    import inst_fetch_queue_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            misalign;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               push;
    logic               pop;
    entry_t             wr_entry;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Next pointer/occupancy; flush discards everything, including a same-cycle push.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        cnt_next    = cnt;
        wr_entry.pc       = in_pc;
        wr_entry.inst     = in_inst;
        wr_entry.misalign = pc_misaligned(in_pc[1:0]);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            cnt_next    = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_next = cnt + CNT_W'(1);
                2'b01:   cnt_next = cnt - CNT_W'(1);
                default: cnt_next = cnt;
            endcase
        end
    end

    // Control state; status flags are precomputed from cnt_next so they stay pure flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            cnt         <= cnt_next;
            in_ready_q  <= (cnt_next != CNT_W'(DEPTH));
            out_valid_q <= (cnt_next != CNT_W'(0));
        end
    end

    // Entry storage; only reset scrubs contents, flush just abandons them.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign count        = cnt;
    assign out_pc       = mem[rd_ptr].pc;
    assign out_inst     = mem[rd_ptr].inst;
    assign out_misalign = mem[rd_ptr].misalign;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4).
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam logic [XLEN-1:0] BASE = 64'h0000_0000_8000_0000;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [ILEN-1:0]   in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [ILEN-1:0]   out_inst;
    logic              out_misalign;
    logic              flush;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_misalign (out_misalign),
        .flush        (flush),
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_inst = '0;
        step(); step();
        reset = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_out_inst got %h exp 0", out_inst); end
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", out_misalign); end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_pc = BASE; in_inst = 32'h0000_0413; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got out_valid %b exp 0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_pc !== BASE) begin errors++; $display("FAIL single_out_pc got %h exp %h", out_pc, BASE); end
        checks++; if (out_inst !== 32'h0000_0413) begin errors++; $display("FAIL single_out_inst got %h exp 00000413", out_inst); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL single_misalign got %b exp 0", out_misalign); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got out_valid %b exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = BASE + 64'(4 * i); in_inst = 32'h1000 + 32'(i);
            step();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            checks++; if (out_pc !== BASE) begin errors++; $display("FAIL fill_head_stable[%0d] got %h exp %h", i, out_pc, BASE); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_valid = 1'b1; in_pc = BASE + 64'h10; in_inst = 32'hdead_beef;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d exp 4", count); end
        checks++; if (out_pc !== BASE) begin errors++; $display("FAIL full_reject_head got %h exp %h", out_pc, BASE); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_pc !== BASE + 64'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] got %h exp %h", i, out_pc, BASE + 64'(4 * i)); end
            checks++; if (out_inst !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL drain_inst[%0d] got %h exp %h", i, out_inst, 32'h1000 + 32'(i)); end
            checks++; if (in_ready !== (i != 0)) begin errors++; $display("FAIL drain_in_ready[%0d] got %b exp %b", i, in_ready, i != 0); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got out_valid %b exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
    endtask

    task automatic test_stream();
        in_valid = 1'b1; out_ready = 1'b1; in_pc = BASE; in_inst = 32'h2000;
        step();
        for (int j = 0; j < 20; j++) begin
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", j, count); end
            checks++; if (out_pc !== BASE + 64'(4 * j)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", j, out_pc, BASE + 64'(4 * j)); end
            checks++; if (out_inst !== 32'h2000 + 32'(j)) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", j, out_inst, 32'h2000 + 32'(j)); end
            in_pc = BASE + 64'(4 * (j + 1)); in_inst = 32'h2000 + 32'(j + 1);
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_pc !== BASE + 64'd80) begin errors++; $display("FAIL stream_last_pc got %h exp %h", out_pc, BASE + 64'd80); end
        step();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = BASE + 64'h200 + 64'(4 * i); in_inst = 32'h3000 + 32'(i);
            step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
        flush = 1'b1; in_valid = 1'b1; in_pc = BASE + 64'h100; in_inst = 32'h4000; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_cycle_in_ready got %b exp 1", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        in_valid = 1'b1; in_pc = BASE + 64'h100; in_inst = 32'h4001;
        step();
        in_valid = 1'b0;
        checks++; if (out_pc !== BASE + 64'h100) begin errors++; $display("FAIL flush_new_head got %h exp %h", out_pc, BASE + 64'h100); end
        checks++; if (out_inst !== 32'h4001) begin errors++; $display("FAIL flush_new_inst got %h exp 00004001", out_inst); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_new_count got %0d exp 1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_misalign();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = BASE + 64'h2; in_inst = 32'h5000;
        step();
        in_pc = BASE + 64'h4; in_inst = 32'h5001;
        step();
        in_valid = 1'b0;
        checks++; if (out_pc !== BASE + 64'h2) begin errors++; $display("FAIL misalign_pc got %h exp %h", out_pc, BASE + 64'h2); end
        checks++; if (out_misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got %b exp 1", out_misalign); end
        out_ready = 1'b1;
        step();
        checks++; if (out_pc !== BASE + 64'h4) begin errors++; $display("FAIL misalign_next_pc got %h exp %h", out_pc, BASE + 64'h4); end
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b exp 0", out_misalign); end
        step();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL misalign_drain got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = BASE + 64'h300 + 64'(4 * i); in_inst = 32'h6000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL midrst_pre_count got %0d exp 3", count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL midrst_out_pc got %h exp 0", out_pc); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL midrst_out_inst got %h exp 0", out_inst); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_misalign();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
